// File: rtl/via_serial_link.sv
// VIA 6522 shift-register serial link: generates the CB1 shift clock, frames host->device bytes
// from CB2 and device->host bytes from an inbound FIFO, in keyboard (mode 0) or ADB (mode 1) style.
module via_serial_link #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DIV_KBD = 1300,
  parameter int unsigned DIV_ADB = 168,
  parameter int unsigned CNT_W   = 11,
  parameter int unsigned FIFO_AW = 2
) (
  input  logic              clk32,
  input  logic              _systemReset,
  input  logic              clk8_en_p,
  input  logic              mode,
  input  logic              listen,
  input  logic              cb2_drv,
  output logic              shift_clk,
  output logic              cb2_in,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_strobe,
  output logic [DATA_W-1:0] out_data,
  output logic              out_strobe,
  output logic              busy,
  output logic [FIFO_AW:0]  fifo_level,
  output logic              overflow
);

  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    TX,
    WAIT,
    RX
  } stateType;

  stateType          state;
  logic [CNT_W-1:0]  divCnt;
  logic [CNT_W-1:0]  divMax;
  logic [BIT_W-1:0]  bitCnt;
  logic [DATA_W-1:0] shReg;
  logic [DATA_W-1:0] rxByte;
  logic              atn;
  logic              shifting;

  logic [DATA_W-1:0]  fifoMem [DEPTH];
  logic [FIFO_AW-1:0] wrPtr;
  logic [FIFO_AW-1:0] rdPtr;
  logic               fifoEmpty;
  logic               fifoFull;
  logic               popReq;
  logic               pushOk;
  logic [DATA_W-1:0]  fifoHead;

  assign divMax    = mode ? CNT_W'(DIV_ADB - 1) : CNT_W'(DIV_KBD - 1);
  assign shifting  = (state == TX) || (state == RX);
  assign busy      = (state != IDLE);
  assign fifoEmpty = (fifo_level == '0);
  assign fifoFull  = (fifo_level == (FIFO_AW + 1)'(DEPTH));
  assign fifoHead  = fifoMem[rdPtr];
  assign pushOk    = in_strobe && (!fifoFull || popReq);

  // Pops only happen on the enable that moves the FSM into RX.
  always_comb begin
    popReq = 1'b0;
    if (clk8_en_p && !fifoEmpty) begin
      case (state)
        IDLE:    popReq = mode && !(atn && listen);
        WAIT:    popReq = cb2_drv;
        default: popReq = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk32 or negedge _systemReset) begin
    if (!_systemReset) begin
      state      <= IDLE;
      divCnt     <= '0;
      bitCnt     <= '0;
      shReg      <= '0;
      rxByte     <= '0;
      atn        <= mode;
      shift_clk  <= 1'b1;
      cb2_in     <= 1'b1;
      out_data   <= '0;
      out_strobe <= 1'b0;
    end else if (clk8_en_p) begin
      out_strobe <= 1'b0;
      if (state != RX) cb2_in <= 1'b1;
      if (shifting) begin
        if (divCnt == divMax) begin
          divCnt    <= '0;
          shift_clk <= ~shift_clk;
          if (shift_clk) begin
            // RX byte is shifted out MSB-first rather than indexed by bitCnt.
            if (state == TX) begin
              shReg <= {shReg[DATA_W-2:0], cb2_drv};
            end else begin
              cb2_in <= rxByte[DATA_W-1];
              rxByte <= {rxByte[DATA_W-2:0], 1'b0};
            end
          end else if (bitCnt == BIT_LAST) begin
            bitCnt <= '0;
            if (state == TX) begin
              out_data   <= shReg;
              out_strobe <= 1'b1;
              state      <= mode ? IDLE : WAIT;
            end else begin
              state <= IDLE;
            end
          end else begin
            bitCnt <= bitCnt + 1'b1;
          end
        end else begin
          divCnt <= divCnt + 1'b1;
        end
      end else begin
        divCnt    <= '0;
        shift_clk <= 1'b1;
        case (state)
          IDLE: begin
            if (!mode) begin
              if (!cb2_drv) begin
                state  <= TX;
                bitCnt <= '0;
                shReg  <= '0;
              end
            end else if (atn && listen) begin
              state  <= TX;
              atn    <= 1'b0;
              bitCnt <= '0;
              shReg  <= '0;
            end else begin
              if (cb2_drv) atn <= 1'b1;
              if (popReq) begin
                state  <= RX;
                rxByte <= fifoHead;
                bitCnt <= '0;
              end
            end
          end
          WAIT: begin
            if (popReq) begin
              state  <= RX;
              rxByte <= fifoHead;
              bitCnt <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk32 or negedge _systemReset) begin
    if (!_systemReset) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (popReq) rdPtr <= rdPtr + 1'b1;
      if (in_strobe && !pushOk) overflow <= 1'b1;
      case ({pushOk, popReq})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk32) begin
    if (pushOk) fifoMem[wrPtr] <= in_data;
  end

endmodule

// File: tb/tb_via_serial_link.sv
// Directed bench for via_serial_link with short dividers (DIV_KBD=4, DIV_ADB=2).
module tb_via_serial_link;

  logic       clk32 = 1'b0;
  logic       _systemReset;
  logic       clk8_en_p;
  logic       mode;
  logic       listen;
  logic       cb2_drv;
  logic       shift_clk;
  logic       cb2_in;
  logic [7:0] in_data;
  logic       in_strobe;
  logic [7:0] out_data;
  logic       out_strobe;
  logic       busy;
  logic [2:0] fifo_level;
  logic       overflow;

  int nChecks = 0;
  int nPass   = 0;
  int nFail   = 0;

  via_serial_link #(
    .DATA_W (8),
    .DIV_KBD(4),
    .DIV_ADB(2),
    .CNT_W  (11),
    .FIFO_AW(2)
  ) dut (
    .clk32       (clk32),
    ._systemReset(_systemReset),
    .clk8_en_p   (clk8_en_p),
    .mode        (mode),
    .listen      (listen),
    .cb2_drv     (cb2_drv),
    .shift_clk   (shift_clk),
    .cb2_in      (cb2_in),
    .in_data     (in_data),
    .in_strobe   (in_strobe),
    .out_data    (out_data),
    .out_strobe  (out_strobe),
    .busy        (busy),
    .fifo_level  (fifo_level),
    .overflow    (overflow)
  );

  always #5 clk32 = ~clk32;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clk8 enable followed by one clk32 cycle without enable.
  task automatic tick();
    clk8_en_p = 1'b1;
    @(negedge clk32);
    clk8_en_p = 1'b0;
    @(negedge clk32);
  endtask

  task automatic push(input logic [7:0] v);
    in_data   = v;
    in_strobe = 1'b1;
    @(negedge clk32);
    in_strobe = 1'b0;
  endtask

  task automatic doReset();
    _systemReset = 1'b0;
    @(negedge clk32);
    @(negedge clk32);
    _systemReset = 1'b1;
    @(negedge clk32);
  endtask

  // Host drives each bit before its falling edge; returns right after the final rising edge.
  task automatic txBits(input logic [7:0] b, input int half);
    for (int i = 7; i >= 0; i--) begin
      cb2_drv = b[i];
      repeat (half) tick();
      check("tx clk low", shift_clk, 1'b0);
      if (i == 0) begin
        repeat (half - 1) tick();
        check("tx strobe early", out_strobe, 1'b0);
        tick();
      end else begin
        repeat (half) tick();
      end
    end
  endtask

  // Expects the FSM to have just entered RX.
  task automatic rxFrame(input logic [7:0] exp, input int half);
    for (int i = 7; i >= 0; i--) begin
      repeat (half - 1) tick();
      check("rx clk high", shift_clk, 1'b1);
      tick();
      check("rx clk low", shift_clk, 1'b0);
      check($sformatf("rx %0h bit %0d", exp, i), cb2_in, exp[i]);
      repeat (half) tick();
    end
  endtask

  initial begin
    _systemReset = 1'b0;
    clk8_en_p    = 1'b0;
    mode         = 1'b0;
    listen       = 1'b0;
    cb2_drv      = 1'b1;
    in_data      = '0;
    in_strobe    = 1'b0;
    @(negedge clk32);
    @(negedge clk32);
    check("rst shift_clk", shift_clk, 1'b1);
    check("rst cb2_in", cb2_in, 1'b1);
    check("rst out_data", out_data, 8'h00);
    check("rst out_strobe", out_strobe, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst fifo_level", fifo_level, 3'd0);
    check("rst overflow", overflow, 1'b0);
    _systemReset = 1'b1;
    @(negedge clk32);

    // 1: keyboard-mode host->device byte A5
    cb2_drv = 1'b0;
    tick();
    check("t1 busy tx", busy, 1'b1);
    txBits(8'hA5, 4);
    check("t1 out_data", out_data, 8'hA5);
    check("t1 strobe", out_strobe, 1'b1);
    check("t1 busy wait", busy, 1'b1);
    check("t1 clk idle", shift_clk, 1'b1);
    tick();
    check("t1 strobe width", out_strobe, 1'b0);
    check("t1 still wait", busy, 1'b1);

    // 2: device reply 3C after host releases CB2
    push(8'h3C);
    check("t2 level push", fifo_level, 3'd1);
    tick();
    check("t2 busy rx", busy, 1'b1);
    check("t2 level pop", fifo_level, 3'd0);
    check("t2 cb2_in pre", cb2_in, 1'b1);
    rxFrame(8'h3C, 4);
    check("t2 idle", busy, 1'b0);
    check("t2 level end", fifo_level, 3'd0);
    tick();
    check("t2 cb2_in release", cb2_in, 1'b1);
    check("t2 no new tx", busy, 1'b0);

    // 3: ADB command 2C, then reply 80
    mode    = 1'b1;
    cb2_drv = 1'b1;
    listen  = 1'b1;
    tick();
    check("t3 atn set", busy, 1'b0);
    tick();
    check("t3 busy tx", busy, 1'b1);
    txBits(8'h2C, 2);
    check("t3 out_data", out_data, 8'h2C);
    check("t3 strobe", out_strobe, 1'b1);
    check("t3 no wait", busy, 1'b0);
    listen = 1'b0;
    push(8'h80);
    check("t3 level", fifo_level, 3'd1);
    tick();
    check("t3 rx start", busy, 1'b1);
    check("t3 level pop", fifo_level, 3'd0);
    rxFrame(8'h80, 2);
    check("t3 idle", busy, 1'b0);

    // 4: overflow while transmitting, then FIFO order
    cb2_drv = 1'b1;
    listen  = 1'b1;
    tick();
    tick();
    check("t4 busy tx", busy, 1'b1);
    listen = 1'b0;
    for (int k = 1; k <= 5; k++) push(8'(k));
    check("t4 level full", fifo_level, 3'd4);
    check("t4 overflow", overflow, 1'b1);
    txBits(8'hC3, 2);
    check("t4 out_data", out_data, 8'hC3);
    check("t4 idle", busy, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("t4 rx start", busy, 1'b1);
      check("t4 level", fifo_level, 3'(4 - k));
      rxFrame(8'(k), 2);
    end
    check("t4 drained", busy, 1'b0);
    check("t4 overflow sticky", overflow, 1'b1);

    // 5: push and pop in the same cycle while full
    mode    = 1'b1;
    cb2_drv = 1'b0;
    doReset();
    check("t5 rst overflow", overflow, 1'b0);
    check("t5 rst level", fifo_level, 3'd0);
    for (int k = 1; k <= 4; k++) push(8'(k));
    check("t5 level full", fifo_level, 3'd4);
    check("t5 busy idle", busy, 1'b0);
    clk8_en_p = 1'b1;
    in_data   = 8'h05;
    in_strobe = 1'b1;
    @(negedge clk32);
    clk8_en_p = 1'b0;
    in_strobe = 1'b0;
    @(negedge clk32);
    check("t5 level same", fifo_level, 3'd4);
    check("t5 no overflow", overflow, 1'b0);
    check("t5 rx start", busy, 1'b1);
    rxFrame(8'h01, 2);

    // 6: reset in the middle of a keyboard-mode frame
    mode = 1'b0;
    doReset();
    cb2_drv = 1'b0;
    tick();
    check("t6 busy tx", busy, 1'b1);
    for (int i = 7; i >= 4; i--) begin
      cb2_drv = 1'b1;
      repeat (8) tick();
    end
    cb2_drv = 1'b0;
    repeat (4) tick();
    check("t6 clk low bit3", shift_clk, 1'b0);
    #2 _systemReset = 1'b0;
    #1;
    check("t6 async shift_clk", shift_clk, 1'b1);
    check("t6 async cb2_in", cb2_in, 1'b1);
    check("t6 async busy", busy, 1'b0);
    cb2_drv = 1'b1;
    @(negedge clk32);
    _systemReset = 1'b1;
    @(negedge clk32);
    begin
      logic sawStrobe;
      sawStrobe = 1'b0;
      repeat (70) begin
        tick();
        if (out_strobe) sawStrobe = 1'b1;
      end
      check("t6 no strobe", sawStrobe, 1'b0);
    end
    check("t6 out_data", out_data, 8'h00);
    check("t6 idle", busy, 1'b0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
